shiftreg_serializer_6b: RTL and testbench

Parallel-in, serial-out transmitter that drives the `ShiftReg_6b` receiver (`BitIn`, `Shift`, `Rst`) from the system clock. It accepts a WIDTH-bit segment pattern with a valid/ready handshake. It then emits one data bit per shift pulse, with programmable setup and pulse widths. It can also issue a reset pulse to the receiver, so the game logic can rewrite or clear a segment register without touching its shift clock directly.

---
 rtl/segrunner_pkg.sv | 22 ++
 rtl/shiftreg_serializer_6b_if.sv | 23 ++
 rtl/phase_counter.sv | 26 ++
 rtl/shiftreg_serializer_6b.sv | 128 ++++++++++++
 tb/tb_shiftreg_serializer_6b.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/segrunner_pkg.sv
// Shared types and helpers for the segment-register serializer.
package segrunner_pkg;

  localparam int WIDTH_DEFAULT = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    CLR   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/shiftreg_serializer_6b_if.sv
// Request/serial-link bundle between the game logic and the serializer.
interface shiftreg_serializer_6b_if #(
  parameter int WIDTH = 6
);
  logic             Load;
  logic [WIDTH-1:0] Data;
  logic             Clear;
  logic             Ready;
  logic             BitOut;
  logic             ShiftOut;
  logic             RegRst;
  logic             Done;

  modport master (
    output Load, Data, Clear,
    input  Ready, BitOut, ShiftOut, RegRst, Done
  );

  modport slave (
    input  Load, Data, Clear,
    output Ready, BitOut, ShiftOut, RegRst, Done
  );
endinterface

// File: rtl/phase_counter.sv
// Loadable, saturating down-counter timing the setup, pulse and clear phases.
module phase_counter #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/shiftreg_serializer_6b.sv
// Parallel-in, serial-out driver for a ShiftReg_6b receiver; all outputs registered.
module shiftreg_serializer_6b
  import segrunner_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEFAULT,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  shiftreg_serializer_6b_if.slave sif
);
  localparam int MAXC  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CNT_W = clog2(MAXC);
  localparam int IDX_W = clog2(WIDTH);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_SETUP = SETUP;
  localparam logic [2:0] ST_PULSE = PULSE;
  localparam logic [2:0] ST_CLR   = CLR;
  localparam logic [2:0] ST_DONE  = DONE;

  localparam logic [CNT_W-1:0] S_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             next_bit;
  logic             ready_q, done_q, shift_q, regrst_q, bit_q;

  phase_counter #(.W(CNT_W)) u_phase (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        // Clear wins over a simultaneous Load; the Load is dropped.
        if (sif.Clear) begin
          state_d  = ST_CLR;
          cnt_load = 1'b1;
          cnt_val  = P_LD;
        end else if (sif.Load) begin
          state_d  = ST_SETUP;
          buf_d    = sif.Data;
          idx_d    = '0;
          cnt_load = 1'b1;
          cnt_val  = S_LD;
        end
      end
      ST_SETUP: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_d  = ST_PULSE;
          cnt_load = 1'b1;
          cnt_val  = P_LD;
        end
      end
      ST_PULSE: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          if (idx_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SETUP;
            buf_d    = (MSB_FIRST != 0) ? (buf_q << 1) : (buf_q >> 1);
            idx_d    = idx_q + IDX_W'(1);
            cnt_load = 1'b1;
            cnt_val  = S_LD;
          end
        end
      end
      ST_CLR: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign next_bit = (MSB_FIRST != 0) ? buf_d[WIDTH-1] : buf_d[0];

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      buf_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      shift_q  <= 1'b0;
      regrst_q <= 1'b1;
      bit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      ready_q  <= (state_d == ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      shift_q  <= (state_d == ST_PULSE);
      regrst_q <= (state_d != ST_CLR);
      if (state_d == ST_SETUP && state_q != ST_SETUP) bit_q <= next_bit;
    end
  end

  assign sif.Ready    = ready_q;
  assign sif.Done     = done_q;
  assign sif.ShiftOut = shift_q;
  assign sif.RegRst   = regrst_q;
  assign sif.BitOut   = bit_q;
endmodule

// File: tb/tb_shiftreg_serializer_6b.sv
// Bench: timeline model of frames/clears checked every cycle on two parameter sets.
module tb_shiftreg_serializer_6b;
  localparam int W = 6;

  int sc [2] = '{1, 2};
  int pc [2] = '{1, 3};
  int mb [2] = '{1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n [2];
  logic         load  [2];
  logic         clr   [2];
  logic [W-1:0] data  [2];
  logic [4:0]   out   [2];   // {Ready, Done, ShiftOut, RegRst, BitOut}

  shiftreg_serializer_6b_if #(.WIDTH(W)) ifa ();
  shiftreg_serializer_6b_if #(.WIDTH(W)) ifb ();

  assign ifa.Load = load[0];
  assign ifa.Clear = clr[0];
  assign ifa.Data = data[0];
  assign ifb.Load = load[1];
  assign ifb.Clear = clr[1];
  assign ifb.Data = data[1];
  assign out[0] = {ifa.Ready, ifa.Done, ifa.ShiftOut, ifa.RegRst, ifa.BitOut};
  assign out[1] = {ifb.Ready, ifb.Done, ifb.ShiftOut, ifb.RegRst, ifb.BitOut};

  shiftreg_serializer_6b #(.WIDTH(W), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .MSB_FIRST(1))
    dut_a (.Clk(clk), .Rst(rst_n[0]), .sif(ifa));
  shiftreg_serializer_6b #(.WIDTH(W), .SETUP_CYCLES(2), .PULSE_CYCLES(3), .MSB_FIRST(0))
    dut_b (.Clk(clk), .Rst(rst_n[1]), .sif(ifb));

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // Model: kind 0 idle, 1 frame, 2 clear; t = cycles since the accept edge.
  int           kind  [2] = '{0, 0};
  int           t     [2] = '{0, 0};
  logic [W-1:0] dat   [2];
  logic         lastb [2] = '{1'b0, 1'b0};

  // Receiver model and event counters fed from the DUT pins.
  logic [W-1:0] rx      [2] = '{'0, '0};
  logic         so_prev [2] = '{1'b0, 1'b0};
  int           npulse  [2] = '{0, 0};
  int           ndone   [2] = '{0, 0};
  int           nrrst   [2] = '{0, 0};

  function automatic logic bitof(int k, int i);
    int j;
    j = (mb[k] != 0) ? (W - 1 - i) : i;
    return dat[k][j];
  endfunction

  function automatic logic [4:0] expo(int k);
    int   per, n;
    logic r, d, s, g, b;
    per = sc[k] + pc[k];
    n = W * per;
    r = (kind[k] == 0); d = 1'b0; s = 1'b0; g = 1'b1; b = lastb[k];
    if (kind[k] == 1) begin
      if (t[k] < n) begin
        s = ((t[k] % per) >= sc[k]);
        b = bitof(k, t[k] / per);
      end else begin
        d = 1'b1;
        b = bitof(k, W - 1);
      end
    end else if (kind[k] == 2) begin
      if (t[k] < pc[k]) g = 1'b0;
      else              d = 1'b1;
    end
    return {r, d, s, g, b};
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_n[k] !== 1'b1) begin
        kind[k] = 0; t[k] = 0; lastb[k] = 1'b0;
      end else if (kind[k] == 0) begin
        if (clr[k]) begin
          kind[k] = 2; t[k] = 0;
        end else if (load[k]) begin
          kind[k] = 1; t[k] = 0; dat[k] = data[k];
          lastb[k] = bitof(k, W - 1);
        end
      end else begin
        t[k]++;
        if ((kind[k] == 1 && t[k] > W * (sc[k] + pc[k])) || (kind[k] == 2 && t[k] > pc[k]))
          kind[k] = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (out[k] !== expo(k)) begin
          bad++;
          $display("FAIL cycle_out[%0d] t=%0t: got %b expected %b", k, $time, out[k], expo(k));
        end
        if (!out[k][1]) begin
          rx[k] = '0; nrrst[k]++;
        end else if (out[k][2] && !so_prev[k]) begin
          rx[k] = {rx[k][W-2:0], out[k][0]}; npulse[k]++;
        end
        so_prev[k] = out[k][2];
        if (out[k][3]) ndone[k]++;
      end
    end
  end

  // Issue a request, then follow the DUT until Done (bounded). Optionally fires a
  // busy Load of all-ones at cycle inj_at.
  task automatic run(input int k, input logic ld, input logic cl, input logic [W-1:0] d,
                     input int inj_at, output int n, output int fhi, output int nhi,
                     output int fb);
    load[k] = ld; clr[k] = cl; data[k] = d;
    @(negedge clk);
    load[k] = 1'b0; clr[k] = 1'b0;
    n = 0; fhi = -1; nhi = 0; fb = -1;
    while (!out[k][3] && n < 200) begin
      if (out[k][2]) begin
        if (fhi < 0) begin fhi = n; fb = int'(out[k][0]); end
        nhi++;
      end
      if (n == inj_at) begin load[k] = 1'b1; data[k] = '1; end
      else load[k] = 1'b0;
      @(negedge clk);
      n++;
    end
    load[k] = 1'b0;
  endtask

  initial begin
    int n, fhi, nhi, fb;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; load[k] = 1'b0; clr[k] = 1'b0; data[k] = '0;
    end
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    chk("reset_a", int'(out[0]), 5'b10010);
    chk("reset_b", int'(out[1]), 5'b10010);

    // Default frame, MSB first.
    npulse[0] = 0;
    run(0, 1'b1, 1'b0, 6'b110010, -1, n, fhi, nhi, fb);
    chk("frame_done_at", n, 12);
    chk("frame_pulses", npulse[0], 6);
    chk("frame_rx", int'(rx[0]), 6'b110010);
    chk("frame_first_bit", fb, 1);
    @(negedge clk);
    chk("frame_ready_at13", int'(out[0][4]), 1);

    // Clear wins over simultaneous Load.
    npulse[0] = 0; nrrst[0] = 0;
    run(0, 1'b1, 1'b1, 6'b000000, -1, n, fhi, nhi, fb);
    chk("clear_done_at", n, 1);
    chk("clear_rrst_cycles", nrrst[0], 1);
    chk("clear_no_shift", npulse[0], 0);
    chk("clear_rx", int'(rx[0]), 0);
    @(negedge clk);
    chk("clear_ready", int'(out[0][4]), 1);
    run(0, 1'b1, 1'b0, 6'b000000, -1, n, fhi, nhi, fb);
    chk("zero_frame_pulses", npulse[0], 6);
    chk("zero_frame_rx", int'(rx[0]), 0);
    @(negedge clk);

    // S=2, P=3, LSB first.
    npulse[1] = 0;
    run(1, 1'b1, 1'b0, 6'b000001, -1, n, fhi, nhi, fb);
    chk("slow_done_at", n, 30);
    chk("slow_first_high", fhi, 2);
    chk("slow_high_cycles", nhi, 18);
    chk("slow_first_bit", fb, 1);
    chk("slow_rx", int'(rx[1]), 6'b100000);
    @(negedge clk);

    // Load during bit 2 is ignored; Data is all-ones afterwards too.
    run(0, 1'b1, 1'b0, 6'b101101, 4, n, fhi, nhi, fb);
    chk("busy_done_at", n, 12);
    chk("busy_rx", int'(rx[0]), 6'b101101);
    @(negedge clk);

    // Reset during bit 3 abandons the frame.
    load[0] = 1'b1; data[0] = 6'b011011;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (6) @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("midrst_out", int'(out[0]), 5'b10010);
    ndone[0] = 0;
    rst_n[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", ndone[0], 0);

    // Random traffic on both instances, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        load[k]  = ($urandom % 4) == 0;
        clr[k]   = ($urandom % 16) == 0;
        data[k]  = W'($urandom);
        rst_n[k] = ($urandom % 256) != 0;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      load[k] = 1'b0; clr[k] = 1'b0; rst_n[k] = 1'b1;
    end
    repeat (40) @(negedge clk);
    chk("final_idle_a", int'(out[0][4]), 1);
    chk("final_idle_b", int'(out[1][4]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
